// File: rtl/if_id_if.sv
// Handshake bundle between fetch, the IF/ID boundary buffer and decode.
// master: fetch and decode side; slave: the pipeline buffer.
interface if_id_if #(parameter int DATA_W = 16);
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc;
  logic              if_ready;
  logic              id_stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [DATA_W-1:0] id_pc;

  modport master (
    output if_valid, if_instr, if_pc, id_stall, flush,
    input  if_ready, id_valid, id_instr, id_pc
  );

  modport slave (
    input  if_valid, if_instr, if_pc, id_stall, flush,
    output if_ready, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID boundary: two-entry elastic buffer (output + skid register) with flush-to-bubble.
// Optional IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
//
// state | meaning
// EMPTY | nothing buffered, id_valid low, NOP on id_instr
// ONE   | output register holds the instruction seen by decode
// FULL  | output and skid registers both valid, fetch held off
module if_id_pipe #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic      clk,
  input  logic      rst,
  if_id_if.slave    bus
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] skid_instr;
  logic [DATA_W-1:0] skid_pc;
  logic              ready;
  logic              accept;
  logic              consume;

  assign accept  = bus.if_valid & ready;
  assign consume = out_valid & ~bus.id_stall;

  assign bus.if_ready = ready;
  assign bus.id_valid = out_valid;
  assign bus.id_instr = out_instr;
  assign bus.id_pc    = out_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_instr  <= NOP_INSTR;
      out_pc     <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      ready      <= 1'b1;
    end else if (bus.flush) begin
      // id_pc deliberately keeps its last value across the bubble
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      ready     <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_instr <= bus.if_instr;
            out_pc    <= bus.if_pc;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_instr <= bus.if_instr;
            out_pc    <= bus.if_pc;
          end else if (accept) begin
            skid_instr <= bus.if_instr;
            skid_pc    <= bus.if_pc;
            ready      <= 1'b0;
            state      <= FULL;
          end else if (consume) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
            ready     <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_instr <= NOP_INSTR;
          ready     <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && bus.id_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (bus.flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: queue-based reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_if_id_pipe;
  localparam int DATA_W = 16;

  logic clk;
  logic rst;
  if_id_if #(.DATA_W(DATA_W)) bus ();

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  if_id_pipe #(.DATA_W(DATA_W), .NOP_INSTR(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: entries are {instr, pc}, oldest at index 0
  logic [31:0] q[$];
  logic        ready_m;
  logic [15:0] last_pc;
  logic [15:0] stall_m;
  logic [15:0] flush_m;

  task automatic model_reset();
    q.delete();
    ready_m = 1'b1;
    last_pc = 16'h0000;
    stall_m = 16'h0000;
    flush_m = 16'h0000;
  endtask

  task automatic model_update();
    logic acc, con;
    if (rst) begin
      model_reset();
    end else begin
      acc = bus.if_valid && ready_m;
      con = (q.size() > 0) && !bus.id_stall;
      if (q.size() > 0 && bus.id_stall && stall_m != 16'hFFFF) stall_m++;
      if (bus.flush && flush_m != 16'hFFFF) flush_m++;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back({bus.if_instr, bus.if_pc});
      end
      ready_m = (q.size() < 2);
      if (q.size() > 0) last_pc = q[0][15:0];
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [15:0] e_instr;
    e_instr = (q.size() > 0) ? q[0][31:16] : 16'h0000;
    check("id_valid", {15'd0, bus.id_valid}, {15'd0, q.size() > 0});
    check("id_instr", bus.id_instr, e_instr);
    check("id_pc",    bus.id_pc, last_pc);
    check("if_ready", {15'd0, bus.if_ready}, {15'd0, ready_m});
`ifdef IF_ID_PERF_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
    check("flush_cnt", flush_cnt, flush_m);
`endif
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic st, input logic fl);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.id_stall = st;
    bus.flush    = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic lit_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pc, input logic rdy);
    check({tag, "_valid"}, {15'd0, bus.id_valid}, {15'd0, v});
    check({tag, "_instr"}, bus.id_instr, ins);
    check({tag, "_pc"},    bus.id_pc, pc);
    check({tag, "_ready"}, {15'd0, bus.if_ready}, {15'd0, rdy});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    model_reset();
    #1;
    lit_out("reset", 1'b0, 16'h0000, 16'h0000, 1'b1);
    #11 rst = 1'b0;

    // stream three instructions back to back
    drive(1'b1, 16'h1111, 16'd1, 1'b0, 1'b0); cycle();
    lit_out("s1", 1'b1, 16'h1111, 16'd1, 1'b1);
    drive(1'b1, 16'h2222, 16'd2, 1'b0, 1'b0); cycle();
    lit_out("s2", 1'b1, 16'h2222, 16'd2, 1'b1);
    // stall for 3 cycles while 3333 is offered
    drive(1'b1, 16'h3333, 16'd3, 1'b1, 1'b0); cycle();
    lit_out("stall1", 1'b1, 16'h2222, 16'd2, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); cycle();
    lit_out("stall2", 1'b1, 16'h2222, 16'd2, 1'b0);
    cycle();
    lit_out("stall3", 1'b1, 16'h2222, 16'd2, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); cycle();
    lit_out("release", 1'b1, 16'h3333, 16'd3, 1'b1);
    cycle();
    lit_out("drained", 1'b0, 16'h0000, 16'd3, 1'b1);

    // fill to FULL, then flush together with an offered instruction
    drive(1'b1, 16'hAAAA, 16'd10, 1'b1, 1'b0); cycle();
    drive(1'b1, 16'hBBBB, 16'd11, 1'b1, 1'b0); cycle();
    lit_out("full", 1'b1, 16'hAAAA, 16'd10, 1'b0);
    drive(1'b1, 16'hCCCC, 16'd12, 1'b1, 1'b1); cycle();
    lit_out("flush", 1'b0, 16'h0000, 16'd10, 1'b1);
    drive(1'b1, 16'h4444, 16'd13, 1'b0, 1'b0); cycle();
    lit_out("after_flush", 1'b1, 16'h4444, 16'd13, 1'b1);

    // bubble input drains ONE to EMPTY
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); cycle();
    cycle();
    lit_out("bubble", 1'b0, 16'h0000, 16'd13, 1'b1);

    // async reset while FULL, observed before the next edge
    drive(1'b1, 16'h5555, 16'd20, 1'b1, 1'b0); cycle();
    drive(1'b1, 16'h6666, 16'd21, 1'b1, 1'b0); cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    lit_out("async_rst", 1'b0, 16'h0000, 16'h0000, 1'b1);
    cycle();
    // release reset with flush asserted: must stay EMPTY
    drive(1'b1, 16'h7777, 16'd30, 1'b0, 1'b1);
    #2 rst = 1'b0;
    cycle();
    lit_out("rst_flush", 1'b0, 16'h0000, 16'h0000, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
    #2 rst = 1'b1;
    #1 model_reset();
    #2 rst = 1'b0;
    drive(1'b1, 16'h8888, 16'd40, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    repeat (5) cycle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (2) cycle();
    check("stall_cnt_5", stall_cnt, 16'd5);
    check("flush_cnt_2", flush_cnt, 16'd2);
    drive(1'b1, 16'h9999, 16'd41, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    repeat (70000) cycle();
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1); cycle();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Pipeline boundary between the instruction fetch stage and the decode stage of the 16-bit WISC-S15 core. It captures each fetched instruction with its incremented PC and presents it to decode. A two-entry elastic buffer (output register plus skid register) absorbs the in-flight fetch when decode stalls. Branch/jump redirects flush the buffer and force a NOP bubble into decode.

## Interface
- DATA_W, 16, width of the instruction and PC fields.
- NOP_INSTR, 16'h0000, encoding driven on id_instr whenever id_valid is low.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_instr  in  DATA_W  fetched instruction.
- if_pc  in  DATA_W  PC+1 of the fetched instruction.
- if_ready  out  1  buffer can accept; fetch must hold its PC while low.
- id_stall  in  1  decode/hazard unit holds the current instruction.
- flush  in  1  taken branch/jump; discard all buffered and incoming instructions.
- id_valid  out  1  id_instr/id_pc carry a real instruction.
- id_instr  out  DATA_W  instruction to decode.
- id_pc  out  DATA_W  PC+1 paired with id_instr.

## Operation
- Accept = if_valid & if_ready. Consume = id_valid & ~id_stall.
- States: EMPTY (no entry), ONE (output register valid), FULL (output and skid registers valid).
- EMPTY: on accept, load the output register and go to ONE.
- ONE, accept & consume: reload the output register; stay ONE.
- ONE, accept & ~consume: load the skid register; go to FULL.
- ONE, ~accept & consume: go to EMPTY. Otherwise hold.
- FULL: on consume, move skid to output and go to ONE. Otherwise hold. No accept is possible in FULL.
- if_ready is a registered output: 1 in EMPTY and ONE, 0 in FULL. It is never combinationally dependent on id_stall.
- flush has top priority:
  - Next state EMPTY.
  - Any same-cycle accept is discarded.
  - id_valid=0 and id_instr=NOP_INSTR from the next cycle.
  - id_pc holds its last value.
- Whenever id_valid=0, id_instr=NOP_INSTR.
- Entry order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Reset values: state EMPTY, id_valid 0, id_instr NOP_INSTR, id_pc 0, if_ready 1. The skid register contents are don't-care.
- Reset asserted mid-stall or while FULL: all buffered entries are lost immediately, without waiting for a clock edge.

## Timing
- Latency: an accept in EMPTY appears on id_* in the next cycle.
- Throughput: one instruction per cycle while id_stall=0.
- After id_stall rises with the buffer in ONE, one further accept is absorbed by the skid. if_ready then drops the following cycle.
- After id_stall falls while FULL, if_ready returns to 1 one cycle later. The skid entry is presented the cycle after the output entry is consumed.
- flush and id_stall asserted together: flush wins.
- flush and reset deassertion in the same cycle: the block stays EMPTY.

## Configuration
- IF_ID_PERF_CNT_EN defined:
  - Adds output stall_cnt (16 bit), which increments each cycle id_valid & id_stall is true.
  - Adds output flush_cnt (16 bit), which increments each cycle flush is true.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters do not exist. Core behaviour is identical either way.

## Test plan
- Reset then stream: rst pulse; if_valid=1 with instructions 16'h1111, 16'h2222, 16'h3333 (pc 1, 2, 3) on consecutive cycles, id_stall=0. Required: id_* shows them one cycle later in order, id_valid=1 each cycle, if_ready stays 1.
- Stall absorb: while streaming, hold id_stall=1 for 3 cycles. Required: id_instr holds 16'h2222, the skid captures 16'h3333, and if_ready=0 from the second stall cycle. After release, 16'h2222 then 16'h3333 appear with no loss or duplication.
- Flush while FULL: in FULL, assert flush for one cycle together with if_valid. Required: next cycle id_valid=0, id_instr=16'h0000, and if_ready=1. The next accepted 16'h4444 appears one cycle after its accept.
- Async reset mid-stall: in FULL, assert rst between clock edges. Required: id_valid=0, id_instr=NOP_INSTR, id_pc=0, and if_ready=1 immediately, before the next clock edge.
- Bubble input: if_valid=0 for 2 cycles in ONE with id_stall=0. Required: the state goes to EMPTY and id_valid=0 with id_instr=NOP_INSTR.
- With IF_ID_PERF_CNT_EN: 5 stall cycles with id_valid=1 and 2 flush cycles give stall_cnt=5 and flush_cnt=2. Holding stall for 70000 cycles gives stall_cnt=16'hFFFF.
